// File: rtl/biriscv_branch_resolve.sv
// Branch resolution: orders lane results, detects mispredicts, trains next-PC.
// Optional counters enabled by defining BRANCH_RESOLVE_STATS_EN.
module biriscv_branch_resolve #(
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_DEPTH_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        branch0_valid_i,
    input  logic [31:0] branch0_source_i,
    input  logic [31:0] branch0_target_i,
    input  logic        branch0_taken_i,
    input  logic        branch0_pred_taken_i,
    input  logic [31:0] branch0_pred_pc_i,
    input  logic        branch0_is_call_i,
    input  logic        branch0_is_ret_i,
    input  logic        branch0_is_jmp_i,
    input  logic        branch1_valid_i,
    input  logic [31:0] branch1_source_i,
    input  logic [31:0] branch1_target_i,
    input  logic        branch1_taken_i,
    input  logic        branch1_pred_taken_i,
    input  logic [31:0] branch1_pred_pc_i,
    input  logic        branch1_is_call_i,
    input  logic        branch1_is_ret_i,
    input  logic        branch1_is_jmp_i,
    output logic        stall_o,
    output logic        squash_o,
    output logic        npc_request_o,
    output logic        npc_is_taken_o,
    output logic        npc_is_not_taken_o,
    output logic [31:0] npc_source_o,
    output logic [31:0] npc_pc_o,
    output logic        npc_is_call_o,
    output logic        npc_is_ret_o,
    output logic        npc_is_jmp_o,
    output logic [31:0] stat_branches_o,
    output logic [31:0] stat_mispredicts_o
);

    typedef struct packed {
        logic [31:0] source;
        logic [31:0] npc;
        logic        taken;
        logic        mp;
        logic        is_call;
        logic        is_ret;
        logic        is_jmp;
    } event_t;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t state_q;
    state_t state_d;

    event_t ev0;
    event_t ev1;
    event_t head;
    event_t mem_q [FIFO_DEPTH];

    logic accept;
    logic push0;
    logic push1;
    logic pop;
    logic empty;

    logic [FIFO_DEPTH_W-1:0] wr_ptr_q;
    logic [FIFO_DEPTH_W-1:0] rd_ptr_q;
    logic [FIFO_DEPTH_W-1:0] wr_ptr1;
    logic [FIFO_DEPTH_W:0]   count_q;

    // Build per-lane events and their mispredict flags
    always_comb begin
        ev0.source  = branch0_source_i;
        ev0.npc     = branch0_taken_i ? branch0_target_i
                                      : branch0_source_i + 32'd4;
        ev0.taken   = branch0_taken_i;
        ev0.mp      = branch0_valid_i &
                      ((branch0_taken_i != branch0_pred_taken_i) |
                       (branch0_taken_i &
                        (branch0_target_i != branch0_pred_pc_i)));
        ev0.is_call = branch0_is_call_i;
        ev0.is_ret  = branch0_is_ret_i;
        ev0.is_jmp  = branch0_is_jmp_i;
        ev1.source  = branch1_source_i;
        ev1.npc     = branch1_taken_i ? branch1_target_i
                                      : branch1_source_i + 32'd4;
        ev1.taken   = branch1_taken_i;
        ev1.mp      = branch1_valid_i &
                      ((branch1_taken_i != branch1_pred_taken_i) |
                       (branch1_taken_i &
                        (branch1_target_i != branch1_pred_pc_i)));
        ev1.is_call = branch1_is_call_i;
        ev1.is_ret  = branch1_is_ret_i;
        ev1.is_jmp  = branch1_is_jmp_i;
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= RUN;
        else         state_q <= state_d;
    end

    // FSM next state: enter FLUSH on a queued mispredict, leave when it pops
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (squash_o && !(pop && head.mp)) state_d = FLUSH;
            FLUSH: if (pop && head.mp)                state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM outputs: accept lanes only in RUN, lane1 dropped behind a lane0 mispredict
    always_comb begin
        accept   = (state_q == RUN);
        push0    = accept & branch0_valid_i;
        push1    = accept & branch1_valid_i & ~ev0.mp;
        squash_o = (push0 & ev0.mp) | (push1 & ev1.mp);
    end

    // Head selection: an empty queue forwards the oldest incoming event
    always_comb begin
        empty   = (count_q == '0);
        wr_ptr1 = wr_ptr_q + FIFO_DEPTH_W'(push0);
        pop     = ~empty | push0 | push1;
        if (!empty)     head = mem_q[rd_ptr_q];
        else if (push0) head = ev0;
        else            head = ev1;
    end

    assign stall_o = (count_q >= (FIFO_DEPTH_W+1)'(FIFO_DEPTH - 1));

    // Event storage (contents need no reset, validity is tracked by count)
    always_ff @(posedge clk_i) begin
        if (push0) mem_q[wr_ptr_q] <= ev0;
        if (push1) mem_q[wr_ptr1]  <= ev1;
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_W'(push0)
                                 + FIFO_DEPTH_W'(push1);
            rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_W'(pop);
            count_q  <= count_q + (FIFO_DEPTH_W+1)'(push0)
                                + (FIFO_DEPTH_W+1)'(push1)
                                - (FIFO_DEPTH_W+1)'(pop);
        end
    end

    // Registered predictor update: strobes pulse on pop, data holds
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            npc_request_o      <= 1'b0;
            npc_is_taken_o     <= 1'b0;
            npc_is_not_taken_o <= 1'b0;
            npc_source_o       <= 32'd0;
            npc_pc_o           <= 32'd0;
            npc_is_call_o      <= 1'b0;
            npc_is_ret_o       <= 1'b0;
            npc_is_jmp_o       <= 1'b0;
        end else if (pop) begin
            npc_request_o      <= head.mp;
            npc_is_taken_o     <= head.taken;
            npc_is_not_taken_o <= ~head.taken;
            npc_source_o       <= head.source;
            npc_pc_o           <= head.npc;
            npc_is_call_o      <= head.is_call;
            npc_is_ret_o       <= head.is_ret;
            npc_is_jmp_o       <= head.is_jmp;
        end else begin
            npc_request_o      <= 1'b0;
            npc_is_taken_o     <= 1'b0;
            npc_is_not_taken_o <= 1'b0;
            npc_is_call_o      <= 1'b0;
            npc_is_ret_o       <= 1'b0;
            npc_is_jmp_o       <= 1'b0;
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    // Popped-event and mispredict counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_br_q <= 32'd0;
            stat_mp_q <= 32'd0;
        end else if (pop) begin
            stat_br_q <= stat_br_q + 32'd1;
            if (head.mp) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches_o    = stat_br_q;
    assign stat_mispredicts_o = stat_mp_q;
`else
    assign stat_branches_o    = 32'd0;
    assign stat_mispredicts_o = 32'd0;
`endif

`ifndef SYNTHESIS
    // Execute must hold off while the queue is nearly full
    a_no_push_on_stall: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        stall_o |-> !(branch0_valid_i || branch1_valid_i));
`endif

endmodule
